// File: rtl/ascon_permutation_iter.sv
// Iterative ASCON permutation: one round (pc -> ps -> pl) per clock, or two per clock with ASCON_PERM_UNROLL2_EN.
// Latency: N_eff RUN cycles + 1 DONE cycle (ceil(N_eff/2) + 1 unrolled). i_start is ignored while not ready.
package ascon_perm_pkg;
    typedef logic [4:0][63:0] t_state_array;
endpackage

module ascon_permutation_iter
    import ascon_perm_pkg::*;
#(
    parameter int MAX_ROUNDS = 12
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [3:0]   i_rounds,
    input  t_state_array i_state,
    output t_state_array o_state,
    output logic         o_ready,
    output logic         o_busy,
    output logic         o_done,
    output logic [3:0]   o_round
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} t_fsm;

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic t_state_array round_fn(input t_state_array s, input logic [3:0] idx);
        t_state_array x;
        logic [63:0]  t0, t1, t2, t3, t4;
        x = s;
        // Round constant {~idx, idx} is added into the low byte of x2.
        x[2] = x[2] ^ {56'd0, 4'hF - idx, idx};
        x[0] = x[0] ^ x[4];
        x[4] = x[4] ^ x[3];
        x[2] = x[2] ^ x[1];
        t0 = ~x[0] & x[1];
        t1 = ~x[1] & x[2];
        t2 = ~x[2] & x[3];
        t3 = ~x[3] & x[4];
        t4 = ~x[4] & x[0];
        x[0] = x[0] ^ t1;
        x[1] = x[1] ^ t2;
        x[2] = x[2] ^ t3;
        x[3] = x[3] ^ t4;
        x[4] = x[4] ^ t0;
        x[1] = x[1] ^ x[0];
        x[0] = x[0] ^ x[4];
        x[3] = x[3] ^ x[2];
        x[2] = ~x[2];
        x[0] = x[0] ^ rotr(x[0], 19) ^ rotr(x[0], 28);
        x[1] = x[1] ^ rotr(x[1], 61) ^ rotr(x[1], 39);
        x[2] = x[2] ^ rotr(x[2], 1)  ^ rotr(x[2], 6);
        x[3] = x[3] ^ rotr(x[3], 10) ^ rotr(x[3], 17);
        x[4] = x[4] ^ rotr(x[4], 7)  ^ rotr(x[4], 41);
        return x;
    endfunction

    t_fsm         r_fsm;
    t_fsm         w_fsm_nxt;
    t_state_array r_state;
    logic [3:0]   r_round;
    logic [3:0]   w_n_eff;
    logic [3:0]   w_round_nxt;
    t_state_array w_run_state;
    t_state_array w_one;
    logic         w_load;
    logic         w_step;

    assign w_n_eff = (i_rounds > 4'(MAX_ROUNDS)) ? 4'(MAX_ROUNDS) : i_rounds;
    assign w_one   = round_fn(r_state, r_round);

`ifdef ASCON_PERM_UNROLL2_EN
    t_state_array w_two;
    logic         w_single;

    // An odd number of remaining rounds means an odd counter, so that cycle runs one round to finish on index 11.
    assign w_two       = round_fn(w_one, r_round + 4'd1);
    assign w_single    = r_round[0];
    assign w_run_state = w_single ? w_one : w_two;
    assign w_round_nxt = r_round + (w_single ? 4'd1 : 4'd2);
`else
    assign w_run_state = w_one;
    assign w_round_nxt = r_round + 4'd1;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fsm <= S_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        o_ready   = 1'b0;
        o_busy    = 1'b0;
        o_done    = 1'b0;
        w_load    = 1'b0;
        w_step    = 1'b0;
        case (r_fsm)
            S_IDLE: begin
                o_ready = 1'b1;
                if (i_start) begin
                    w_load    = 1'b1;
                    w_fsm_nxt = (w_n_eff == 4'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                o_busy = 1'b1;
                w_step = 1'b1;
                if (w_round_nxt == 4'(MAX_ROUNDS)) begin
                    w_fsm_nxt = S_DONE;
                end
            end
            S_DONE: begin
                o_done    = 1'b1;
                w_fsm_nxt = S_IDLE;
            end
            default: w_fsm_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= '0;
            r_round <= 4'd0;
        end else if (w_load) begin
            r_state <= i_state;
            r_round <= 4'(MAX_ROUNDS) - w_n_eff;
        end else if (w_step) begin
            r_state <= w_run_state;
            r_round <= w_round_nxt;
        end
    end

    assign o_state = r_state;
    assign o_round = r_round;

endmodule

// File: tb/tb_ascon_permutation_iter.sv
// Directed bench for ascon_permutation_iter with a table-lookup S-box reference model.
// Latency expectations follow ASCON_PERM_UNROLL2_EN when the bench is built with it.
module tb_ascon_permutation_iter;
    import ascon_perm_pkg::*;

`ifdef ASCON_PERM_UNROLL2_EN
    localparam bit UNR = 1'b1;
`else
    localparam bit UNR = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         i_start;
    logic [3:0]   i_rounds;
    t_state_array i_state;
    t_state_array o_state;
    logic         o_ready;
    logic         o_busy;
    logic         o_done;
    logic [3:0]   o_round;

    int pass_cnt  = 0;
    int total_cnt = 0;

    ascon_permutation_iter #(.MAX_ROUNDS(12)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_start  (i_start),
        .i_rounds (i_rounds),
        .i_state  (i_state),
        .o_state  (o_state),
        .o_ready  (o_ready),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_round  (o_round)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [4:0] sbox(input logic [4:0] a);
        case (a)
            5'd0:  return 5'h04; 5'd1:  return 5'h0b; 5'd2:  return 5'h1f; 5'd3:  return 5'h14;
            5'd4:  return 5'h1a; 5'd5:  return 5'h15; 5'd6:  return 5'h09; 5'd7:  return 5'h02;
            5'd8:  return 5'h1b; 5'd9:  return 5'h05; 5'd10: return 5'h08; 5'd11: return 5'h12;
            5'd12: return 5'h1d; 5'd13: return 5'h03; 5'd14: return 5'h06; 5'd15: return 5'h1c;
            5'd16: return 5'h1e; 5'd17: return 5'h13; 5'd18: return 5'h07; 5'd19: return 5'h0e;
            5'd20: return 5'h00; 5'd21: return 5'h0d; 5'd22: return 5'h11; 5'd23: return 5'h18;
            5'd24: return 5'h10; 5'd25: return 5'h0c; 5'd26: return 5'h01; 5'd27: return 5'h19;
            5'd28: return 5'h16; 5'd29: return 5'h0a; 5'd30: return 5'h0f; default: return 5'h17;
        endcase
    endfunction

    function automatic logic [63:0] m_rot(input logic [63:0] x, input int n);
        logic [127:0] d;
        d = {x, x} >> n;
        return d[63:0];
    endfunction

    function automatic t_state_array m_round(input t_state_array s, input int i);
        t_state_array y;
        logic [4:0]   a, b;
        logic [7:0]   c;
        c = 8'(((15 - i) << 4) | i);
        s[2] = s[2] ^ {56'd0, c};
        for (int j = 0; j < 64; j++) begin
            a = {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
            b = sbox(a);
            y[0][j] = b[4]; y[1][j] = b[3]; y[2][j] = b[2]; y[3][j] = b[1]; y[4][j] = b[0];
        end
        s[0] = y[0] ^ m_rot(y[0], 19) ^ m_rot(y[0], 28);
        s[1] = y[1] ^ m_rot(y[1], 61) ^ m_rot(y[1], 39);
        s[2] = y[2] ^ m_rot(y[2], 1)  ^ m_rot(y[2], 6);
        s[3] = y[3] ^ m_rot(y[3], 10) ^ m_rot(y[3], 17);
        s[4] = y[4] ^ m_rot(y[4], 7)  ^ m_rot(y[4], 41);
        return s;
    endfunction

    function automatic t_state_array m_perm(input t_state_array s, input int n);
        if (n > 12) n = 12;
        for (int i = 12 - n; i < 12; i++) s = m_round(s, i);
        return s;
    endfunction

    function automatic void exp_seq(input int n, output logic [63:0] seq, output int len);
        int idx;
        seq = '0;
        len = 0;
        if (n > 12) n = 12;
        idx = 12 - n;
        if (UNR && (n % 2 == 1)) begin
            seq = {seq[59:0], 4'(idx)}; len++; idx++;
        end
        while (idx < 12) begin
            seq = {seq[59:0], 4'(idx)}; len++;
            idx += UNR ? 2 : 1;
        end
    endfunction

    function automatic t_state_array rand_state();
        t_state_array s;
        for (int w = 0; w < 5; w++) s[w] = {$urandom, $urandom};
        return s;
    endfunction

    function automatic t_state_array pat(input logic [63:0] base);
        t_state_array s;
        for (int w = 0; w < 5; w++) s[w] = base ^ 64'(w);
        return s;
    endfunction

    // Starts one permutation and follows it to its done pulse; cycle 1 is the first cycle after acceptance.
    task automatic run_perm(input t_state_array st, input logic [3:0] n, output int done_cyc,
                            output t_state_array res, output logic [63:0] rseq, output int rlen,
                            output logic [3:0] first_round);
        @(negedge clk);
        chk("ready_before_start", 320'(o_ready), 320'(1));
        i_start  = 1'b1;
        i_state  = st;
        i_rounds = n;
        @(posedge clk);
        done_cyc = -1;
        res = '0;
        rseq = '0;
        rlen = 0;
        first_round = 4'hF;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            i_start  = 1'b0;
            i_state  = rand_state();
            i_rounds = 4'($urandom_range(0, 15));
            if (o_busy) begin
                if (rlen == 0) first_round = o_round;
                rseq = {rseq[59:0], o_round};
                rlen++;
            end
            if (o_done) begin
                done_cyc = c;
                res = o_state;
                chk("ready_low_in_done", 320'(o_ready), 320'(0));
                chk("busy_low_in_done", 320'(o_busy), 320'(0));
                break;
            end
        end
        if (done_cyc < 0) begin
            total_cnt++;
            $display("FAIL timeout: no o_done within 40 cycles for rounds=%0d", n);
        end
        @(negedge clk);
        chk("ready_after_done", 320'(o_ready), 320'(1));
        chk("done_single_pulse", 320'(o_done), 320'(0));
        @(negedge clk);
        chk("result_hold", o_state, res);
    endtask

    typedef struct {
        logic [3:0]   n;
        t_state_array st;
        int           done1;
        int           done2;
        logic [3:0]   first;
    } vec_t;

    vec_t         vecs[8];
    t_state_array res, res12, acc_state;
    logic [63:0]  rseq, eseq;
    logic [3:0]   first;
    int           dcyc, rlen, elen, ndone, last_acc, nacc;

    initial begin
        vecs[0] = '{n: 4'd12, st: '0,                         done1: 13, done2: 7, first: 4'd0};
        vecs[1] = '{n: 4'd6,  st: '0,                         done1: 7,  done2: 4, first: 4'd6};
        vecs[2] = '{n: 4'd8,  st: pat(64'h0123456789ABCDEF), done1: 9,  done2: 5, first: 4'd4};
        vecs[3] = '{n: 4'd0,  st: pat(64'h0123456789ABCDEF), done1: 1,  done2: 1, first: 4'hF};
        vecs[4] = '{n: 4'd15, st: '0,                         done1: 13, done2: 7, first: 4'd0};
        vecs[5] = '{n: 4'd1,  st: pat(64'hDEADBEEFCAFEF00D), done1: 2,  done2: 2, first: 4'd11};
        vecs[6] = '{n: 4'd7,  st: pat(64'hDEADBEEFCAFEF00D), done1: 8,  done2: 5, first: 4'd5};
        vecs[7] = '{n: 4'd13, st: pat(64'h0123456789ABCDEF), done1: 13, done2: 7, first: 4'd0};

        rst_n = 1'b0; i_start = 1'b0; i_rounds = 4'd0; i_state = '0;
        #2;
        chk("reset_ready", 320'(o_ready), 320'(1));
        chk("reset_busy",  320'(o_busy),  320'(0));
        chk("reset_done",  320'(o_done),  320'(0));
        chk("reset_round", 320'(o_round), 320'(0));
        chk("reset_state", o_state, '0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 8; v++) begin
            run_perm(vecs[v].st, vecs[v].n, dcyc, res, rseq, rlen, first);
            chk($sformatf("done_cycle[%0d]", v), 320'(dcyc), 320'(UNR ? vecs[v].done2 : vecs[v].done1));
            chk($sformatf("result[%0d]", v), res, m_perm(vecs[v].st, int'(vecs[v].n)));
            chk($sformatf("first_round[%0d]", v), 320'(first), 320'(vecs[v].first));
            exp_seq(int'(vecs[v].n), eseq, elen);
            chk($sformatf("round_seq[%0d]", v), {192'(rlen), 64'd0, rseq}, {192'(elen), 64'd0, eseq});
            if (v == 0) res12 = res;
            if (v == 3) chk("passthrough", res, vecs[v].st);
            if (v == 4) chk("n15_equals_n12", res, res12);
        end

        // Reset in the middle of an N=12 run.
        @(negedge clk);
        i_start = 1'b1; i_rounds = 4'd12; i_state = pat(64'h0123456789ABCDEF);
        @(posedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            i_start = 1'b0;
        end
        chk("busy_before_abort", 320'(o_busy), 320'(1));
        rst_n = 1'b0;
        #1;
        chk("abort_state", o_state, '0);
        chk("abort_ready", 320'(o_ready), 320'(1));
        chk("abort_busy",  320'(o_busy),  320'(0));
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (o_done) ndone++;
        end
        chk("no_done_after_abort", 320'(ndone), 320'(0));
        run_perm(pat(64'h0F1E2D3C4B5A6978), 4'd12, dcyc, res, rseq, rlen, first);
        chk("post_abort_result", res, m_perm(pat(64'h0F1E2D3C4B5A6978), 12));
        chk("post_abort_done_cycle", 320'(dcyc), 320'(UNR ? 7 : 13));

        // i_start held high: only IDLE cycles accept, and later i_state changes must not leak in.
        last_acc = -1; nacc = 0; ndone = 0; acc_state = '0;
        i_rounds = 4'd12;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            i_start = 1'b1;
            if (o_done) begin
                ndone++;
                chk($sformatf("held_start_result[%0d]", ndone), o_state, m_perm(acc_state, 12));
            end
            i_state = rand_state();
            if (o_ready) begin
                if (last_acc >= 0)
                    chk($sformatf("held_start_spacing[%0d]", nacc), 320'(c - last_acc), 320'(UNR ? 8 : 14));
                last_acc = c;
                nacc++;
                acc_state = i_state;
            end
        end
        chk("held_start_accepts", 320'(nacc), 320'(UNR ? 4 : 3));
        chk("held_start_dones", 320'(ndone), 320'(UNR ? 3 : 2));
        @(negedge clk);
        i_start = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ascon_permutation_iter.md
Name: ascon_permutation_iter

Overview:
- Iterative, multi-cycle ASCON permutation engine. It owns the 320-bit state register, the round counter and the control FSM, and drives the round index into the combinational round datapath.
- The datapath is the existing constant addition layer (pc), then the substitution layer (ps), then the linear layer (pl), one full round per clock.
- It is the sequencing end of the round-index interface: it generates the round numbers that the constant addition layer consumes.
- It serves both the pa (12-round) and pb (6/8-round) invocations of the mode controller through a start/done handshake.

Parameters:
- MAX_ROUNDS, 12, total rounds of the full permutation. Also the base for the constant index computation; fixed to 12 for ASCON.

Ports:
- i_clk  input  1  clock, all state updated on rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_start  input  1  request a permutation; accepted only when o_ready=1
- i_rounds  input  4  number of rounds N to execute; sampled with accepted i_start
- i_state  input  t_state_array (5x64)  state to permute; sampled with accepted i_start
- o_state  output  t_state_array (5x64)  state register contents; the permutation result when o_done/o_ready
- o_ready  output  1  idle, can accept i_start
- o_busy  output  1  rounds in progress
- o_done  output  1  single-cycle pulse, result valid on o_state
- o_round  output  4  current constant-addition round index fed to the datapath (debug/observability)

Behaviour:
- Reset (asynchronous, i_rst_n=0):
  - FSM to IDLE; state register cleared to all zero; round counter 0.
  - o_ready=1, o_busy=0, o_done=0, o_round=0.
- Reset asserted mid-operation aborts the permutation immediately. There is no partial result and no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - o_ready=1.
  - On i_start=1: load the state register from i_state; load the round counter with MAX_ROUNDS - N_eff.
  - Go to RUN if N_eff>0, else to DONE.
- N_eff:
  - i_rounds clamped: values 13..15 are treated as 12.
  - i_rounds=0 gives N_eff=0, a pass-through permutation.
- RUN:
  - Each cycle the state register captures pl(ps(pc(state, counter))); the counter increments.
  - o_round = counter; the constant addition uses index = counter.
  - When the counter equals MAX_ROUNDS-1 and that round is captured, go to DONE.
- Round index sequence:
  - N=12: 0,1,...,11.
  - N=8: 4..11.
  - N=6: 6..11.
  - The last round always uses index 11.
- DONE:
  - o_done=1 for exactly one cycle; o_ready=0 during it. Then return to IDLE.
- o_state holds the result unchanged from the DONE cycle until the next accepted i_start.
- Latency: with i_start accepted at cycle 0, RUN occupies cycles 1..N, DONE is cycle N+1, and the next start is accepted at cycle N+2. For N=0, DONE is cycle 1.
- i_start while RUN or DONE is ignored, not queued. i_rounds and i_state are don't-care except in the accepting cycle.
- o_busy = (FSM==RUN). o_ready = (FSM==IDLE). These are mutually exclusive; neither is high in DONE.
- The round datapath is purely combinational between registers, so there is no intermediate pipelining.

Optional Feature:
- Macro ASCON_PERM_UNROLL2_EN.
- Defined:
  - Two round instances are chained per cycle; the counter advances by 2.
  - For odd N_eff, the first RUN cycle executes a single round so that the index sequence ends at 11.
  - RUN lasts ceil(N_eff/2) cycles; DONE follows immediately.
  - o_round shows the index of the first round executed in the cycle.
- Undefined: one round per cycle, exactly as specified above.
- Results are bit-identical in both builds; only latency differs.

Test Plan:
- Reset: drive i_rst_n=0 mid-RUN (N=12, cycle 5) -> o_state=0 and o_ready=1 immediately; no o_done afterwards; next start runs normally.
- N=12, i_state all zero -> o_round steps 0..11 on cycles 1..12, o_done on cycle 13, o_state equals the golden-model p12(0). Round-0 constant 0xF0 is visible as o_state[2] low byte after the pc stage in the datapath probe.
- N=6 -> o_round steps 6..11 (first constant 0x96); o_done at cycle 7; result matches golden p6. Repeat with N=8, indices 4..11.
- i_rounds=0 with arbitrary state (e.g. word i = 64'h0123456789ABCDEF ^ i) -> o_done at cycle 1, o_state == i_state. i_rounds=15 -> identical result to N=12.
- i_start held high continuously -> starts accepted only in IDLE cycles (every 14 cycles for N=12); a new i_state applied during RUN does not corrupt the result.
- With ASCON_PERM_UNROLL2_EN: N=12 gives done at cycle 7; N=6 at cycle 4; N=7 at cycle 5. Results match the one-round build for 100 random states.
